// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states, parity modes and default timing constants.
// Imported by both the transmit path and the receiver.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEFAULT = 108;
  localparam int DATA_BITS_DEFAULT    = 8;
  localparam int FIFO_DEPTH_DEFAULT   = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } par_mode_e;

  // Raw mode 3 is treated as "no parity".
  function automatic par_mode_e decode_parity(input logic [1:0] mode);
    case (mode)
      2'd1:    return PAR_EVEN;
      2'd2:    return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst,
  input  logic                       i_Push,
  input  logic [WIDTH-1:0]           i_Data,
  input  logic                       i_Pop,
  output logic [WIDTH-1:0]           o_Data,
  output logic                       o_Full,
  output logic                       o_Empty,
  output logic [$clog2(DEPTH+1)-1:0] o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_Full  = (r_count == CW'(DEPTH));
  assign o_Empty = (r_count == '0);
  assign o_Count = r_count;
  assign o_Data  = r_mem[r_rd_ptr];
  assign w_push  = i_Push & ~o_Full;
  assign w_pop   = i_Pop & ~o_Empty;

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_Data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small TX FIFO; sends queued words LSB-first, back-to-back,
// with per-frame latched parity mode and stop-bit count.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int DATA_BITS    = DATA_BITS_DEFAULT,
  parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT
) (
  input  logic                            i_Clk,
  input  logic                            i_Rst,
  // Handshake: a word transfers on a rising edge where i_Tx_DV and o_Tx_Ready are both 1;
  // i_Tx_DV with o_Tx_Ready low drops the word and pulses o_Overflow.
  input  logic                            i_Tx_DV,
  input  logic [DATA_BITS-1:0]            i_Tx_Byte,
  input  logic [1:0]                      i_Parity_Mode,
  input  logic                            i_Two_Stop,
  output logic                            o_Tx_Ready,
  output logic                            o_Tx_Active,
  output logic                            o_Tx_Serial,
  output logic                            o_Tx_Done,
  output logic                            o_Overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_Fifo_Count
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  tx_state_e            r_state,    w_state_next;
  logic [CW-1:0]        r_clk_cnt,  w_clk_cnt_next;
  logic [IW-1:0]        r_idx,      w_idx_next;
  logic [DATA_BITS-1:0] r_data,     w_data_next;
  par_mode_e            r_par_mode, w_par_mode_next;
  logic                 r_two_stop, w_two_stop_next;
  logic                 r_stop2,    w_stop2_next;
  logic                 r_serial,   w_serial_next;
  logic                 r_active,   w_active_next;
  logic                 r_done,     w_done_next;
  logic                 r_overflow;
  logic                 w_pop;
  logic                 w_bit_end;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [DATA_BITS-1:0] w_fifo_data;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_Push  (i_Tx_DV),
    .i_Data  (i_Tx_Byte),
    .i_Pop   (w_pop),
    .o_Data  (w_fifo_data),
    .o_Full  (w_fifo_full),
    .o_Empty (w_fifo_empty),
    .o_Count (o_Fifo_Count)
  );

  assign w_bit_end   = (r_clk_cnt == LAST_CLK);
  assign o_Tx_Ready  = ~w_fifo_full;
  assign o_Tx_Active = r_active;
  assign o_Tx_Serial = r_serial;
  assign o_Tx_Done   = r_done;
  assign o_Overflow  = r_overflow;

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state    <= IDLE;
      r_clk_cnt  <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_par_mode <= PAR_NONE;
      r_two_stop <= 1'b0;
      r_stop2    <= 1'b0;
      r_serial   <= 1'b1;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_clk_cnt  <= w_clk_cnt_next;
      r_idx      <= w_idx_next;
      r_data     <= w_data_next;
      r_par_mode <= w_par_mode_next;
      r_two_stop <= w_two_stop_next;
      r_stop2    <= w_stop2_next;
      r_serial   <= w_serial_next;
      r_active   <= w_active_next;
      r_done     <= w_done_next;
      r_overflow <= i_Tx_DV & w_fifo_full;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_clk_cnt_next  = r_clk_cnt;
    w_idx_next      = r_idx;
    w_data_next     = r_data;
    w_par_mode_next = r_par_mode;
    w_two_stop_next = r_two_stop;
    w_stop2_next    = r_stop2;
    w_serial_next   = r_serial;
    w_active_next   = r_active;
    w_done_next     = 1'b0;
    w_pop           = 1'b0;

    if (r_state != IDLE) w_clk_cnt_next = w_bit_end ? '0 : r_clk_cnt + CW'(1);

    case (r_state)
      IDLE: begin
        w_serial_next = 1'b1;
        w_pop         = ~w_fifo_empty;
      end
      START: begin
        if (w_bit_end) begin
          w_state_next  = DATA;
          w_idx_next    = '0;
          w_serial_next = r_data[0];
        end
      end
      DATA: begin
        if (w_bit_end) begin
          if (r_idx == LAST_IDX) begin
            if (r_par_mode == PAR_NONE) begin
              w_state_next  = STOP;
              w_stop2_next  = 1'b0;
              w_serial_next = 1'b1;
            end else begin
              w_state_next  = PARITY;
              w_serial_next = (r_par_mode == PAR_ODD) ? ~(^r_data) : ^r_data;
            end
          end else begin
            w_idx_next    = r_idx + IW'(1);
            w_serial_next = r_data[w_idx_next];
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_next  = STOP;
          w_stop2_next  = 1'b0;
          w_serial_next = 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          if (r_two_stop && !r_stop2) begin
            w_stop2_next = 1'b1;
          end else begin
            w_done_next = 1'b1;
            if (w_fifo_empty) begin
              w_state_next  = IDLE;
              w_active_next = 1'b0;
            end else begin
              w_pop = 1'b1;
            end
          end
        end
      end
      default: w_state_next = IDLE;
    endcase

    // A pop always starts a new frame: latch word and framing options, drive the start bit.
    if (w_pop) begin
      w_state_next    = START;
      w_clk_cnt_next  = '0;
      w_data_next     = w_fifo_data;
      w_par_mode_next = decode_parity(i_Parity_Mode);
      w_two_stop_next = i_Two_Stop;
      w_serial_next   = 1'b0;
      w_active_next   = 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8-bit and 7-bit instances at 4 clocks per bit,
// table of single frames plus hand-written burst and mid-frame reset sequences.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FCW   = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic           dv8, dv7;
  logic [7:0]     byte8;
  logic [6:0]     byte7;
  logic [1:0]     pmode;
  logic           two_stop;
  logic           rdy8, act8, ser8, done8, ovf8;
  logic           rdy7, act7, ser7, done7, ovf7;
  logic [FCW-1:0] cnt8, cnt7;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .FIFO_DEPTH(DEPTH)) dut8 (
    .i_Clk(clk), .i_Rst(rst), .i_Tx_DV(dv8), .i_Tx_Byte(byte8),
    .i_Parity_Mode(pmode), .i_Two_Stop(two_stop),
    .o_Tx_Ready(rdy8), .o_Tx_Active(act8), .o_Tx_Serial(ser8),
    .o_Tx_Done(done8), .o_Overflow(ovf8), .o_Fifo_Count(cnt8)
  );

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .FIFO_DEPTH(DEPTH)) dut7 (
    .i_Clk(clk), .i_Rst(rst), .i_Tx_DV(dv7), .i_Tx_Byte(byte7),
    .i_Parity_Mode(pmode), .i_Two_Stop(two_stop),
    .o_Tx_Ready(rdy7), .o_Tx_Active(act7), .o_Tx_Serial(ser7),
    .o_Tx_Done(done7), .o_Overflow(ovf7), .o_Fifo_Count(cnt7)
  );

  typedef struct {
    logic       use7;
    logic [7:0] data;
    logic [1:0] mode;
    logic       two;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  vec_t vecs[8];
  logic [0:0] exp_q[$];
  int checks   = 0;
  int failures = 0;
  int wave_err, act_n, done_n, done_at, low_n;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic ser_of(input logic use7);
    return use7 ? ser7 : ser8;
  endfunction

  function automatic logic act_of(input logic use7);
    return use7 ? act7 : act8;
  endfunction

  function automatic logic done_of(input logic use7);
    return use7 ? done7 : done8;
  endfunction

  function automatic int cnt_of(input logic use7);
    return use7 ? int'(cnt7) : int'(cnt8);
  endfunction

  // Expected line level per clock cycle for one frame.
  task automatic push_frame(input logic use7, input logic [7:0] data, input logic [1:0] mode,
                            input logic two, input logic par);
    int nb;
    nb = use7 ? 7 : 8;
    repeat (CPB) exp_q.push_back(1'b0);
    for (int i = 0; i < nb; i++) repeat (CPB) exp_q.push_back(data[i]);
    if (mode == 2'd1 || mode == 2'd2) repeat (CPB) exp_q.push_back(par);
    repeat (two ? 2 * CPB : CPB) exp_q.push_back(1'b1);
  endtask

  task automatic wave_sample(input logic s);
    logic [0:0] e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 1'b1;
    if (s !== e[0]) wave_err++;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    if (v.use7) begin dv7 = 1'b1; byte7 = v.data[6:0]; end
    else begin dv8 = 1'b1; byte8 = v.data; end
    pmode    = v.mode;
    two_stop = v.two;
    @(negedge clk);
    dv7 = 1'b0;
    dv8 = 1'b0;
    check("latency_idle_line", int'(ser_of(v.use7)), 1);
    check("count_after_push", cnt_of(v.use7), 1);
    exp_q.delete();
    push_frame(v.use7, v.data, v.mode, v.two, v.exp_par);
    wave_err = 0; act_n = 0; done_n = 0; done_at = -1;
    for (int n = 0; n < v.exp_len + 4; n++) begin
      @(negedge clk);
      wave_sample(ser_of(v.use7));
      if (act_of(v.use7)) act_n++;
      if (done_of(v.use7)) begin done_n++; done_at = n; end
      // Framing options change mid-frame; the frame must keep the latched ones.
      if (n == 0) begin
        pmode    = (v.mode == 2'd1) ? 2'd2 : 2'd1;
        two_stop = ~v.two;
      end
    end
    check("frame_waveform", wave_err, 0);
    check("active_cycles", act_n, v.exp_len);
    check("done_pulses", done_n, 1);
    check("done_position", done_at, v.exp_len);
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] words[6];
    vec_t post;

    vecs[0] = '{1'b0, 8'hA5, 2'd0, 1'b0, 1'b0, 40};
    vecs[1] = '{1'b0, 8'h07, 2'd1, 1'b1, 1'b1, 48};
    vecs[2] = '{1'b0, 8'h07, 2'd2, 1'b1, 1'b0, 48};
    vecs[3] = '{1'b0, 8'h00, 2'd3, 1'b1, 1'b0, 44};
    vecs[4] = '{1'b0, 8'hFF, 2'd1, 1'b0, 1'b0, 44};
    vecs[5] = '{1'b0, 8'h80, 2'd2, 1'b0, 1'b0, 44};
    vecs[6] = '{1'b1, 8'h55, 2'd2, 1'b0, 1'b1, 40};
    vecs[7] = '{1'b0, 8'h3C, 2'd1, 1'b1, 1'b0, 48};
    words   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    post    = '{1'b0, 8'hC3, 2'd2, 1'b0, 1'b1, 44};

    rst = 1'b1; dv8 = 1'b0; dv7 = 1'b0; byte8 = '0; byte7 = '0;
    pmode = 2'd0; two_stop = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_serial", int'(ser8), 1);
    check("rst_ready", int'(rdy8), 1);
    check("rst_active", int'(act8), 0);
    check("rst_done", int'(done8), 0);
    check("rst_overflow", int'(ovf8), 0);
    check("rst_count", int'(cnt8), 0);
    check("rst_serial_7", int'(ser7), 1);
    check("rst_ready_7", int'(rdy7), 1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Burst: six writes on consecutive edges; the first is popped at once, the sixth overflows.
    pmode = 2'd0; two_stop = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 5; i++) push_frame(1'b0, words[i], 2'd0, 1'b0, 1'b0);
    wave_err = 0; act_n = 0; done_n = 0;
    for (int c = 0; c < 205; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        wave_sample(ser8);
        if (act8) act_n++;
        if (done8) done_n++;
      end
      if (c == 2) check("push_pop_same_cycle_count", int'(cnt8), 1);
      if (c == 4) check("ready_at_count3", int'(rdy8), 1);
      if (c == 5) begin
        check("count_full", int'(cnt8), 4);
        check("ready_low_full", int'(rdy8), 0);
        check("no_overflow_before", int'(ovf8), 0);
      end
      if (c == 6) begin
        check("overflow_pulse", int'(ovf8), 1);
        check("count_after_overflow", int'(cnt8), 4);
      end
      if (c == 7) check("overflow_one_cycle", int'(ovf8), 0);
      if (c <= 5) begin dv8 = 1'b1; byte8 = words[c]; end
      else dv8 = 1'b0;
    end
    check("burst_waveform", wave_err, 0);
    check("burst_active_cycles", act_n, 200);
    check("burst_done_pulses", done_n, 5);
    exp_q.delete();

    // Reset in the middle of data bit 3 with a second word still queued.
    @(negedge clk); dv8 = 1'b1; byte8 = 8'hA5;
    @(negedge clk); byte8 = 8'h3C;
    @(negedge clk); dv8 = 1'b0;
    done_n = 0; low_n = 0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (n == 17) begin
        check("pre_reset_active", int'(act8), 1);
        check("pre_reset_bit3", int'(ser8), 0);
        check("pre_reset_count", int'(cnt8), 1);
        rst = 1'b1;
      end
      if (n == 18) begin
        check("abort_serial", int'(ser8), 1);
        check("abort_count", int'(cnt8), 0);
        check("abort_active", int'(act8), 0);
        check("abort_ready", int'(rdy8), 1);
        rst = 1'b0;
      end
      if (n >= 18) begin
        if (done8) done_n++;
        if (!ser8) low_n++;
      end
    end
    check("abort_no_done", done_n, 0);
    check("abort_line_idle", low_n, 0);
    run_vec(post);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised next-generation UART transmitter with a built-in transmit FIFO, configurable data width, runtime-selectable parity and stop-bit count. The host pushes words through a valid/ready handshake. The block serialises them LSB-first, back-to-back, with no idle gap between queued frames. It sits between the CPU/MMIO write path and the board TX pin, alongside the existing receiver.

Parameters:
- CLKS_PER_BIT, 108, clock cycles per bit period; must be >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  synchronous reset, active-high
- i_Tx_DV  in  1  write strobe; a word is accepted when i_Tx_DV & o_Tx_Ready at a rising edge
- i_Tx_Byte  in  DATA_BITS  word to send
- i_Parity_Mode  in  2  0=none, 1=even, 2=odd, 3=none; latched at frame start
- i_Two_Stop  in  1  1 = two stop bits; latched at frame start
- o_Tx_Ready  out  1  FIFO not full (registered count < FIFO_DEPTH)
- o_Tx_Active  out  1  a frame is on the line (START through last STOP)
- o_Tx_Serial  out  1  serial line, idle high
- o_Tx_Done  out  1  one-cycle pulse per completed frame
- o_Overflow  out  1  one-cycle pulse when i_Tx_DV is asserted while o_Tx_Ready=0; the word is dropped
- o_Fifo_Count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset values, applied at the first edge with i_Rst=1: o_Tx_Serial=1, o_Tx_Ready=1, o_Tx_Active=0, o_Tx_Done=0, o_Overflow=0, o_Fifo_Count=0. The FIFO is emptied and the FSM returns to IDLE. Reset mid-frame aborts the frame: line high on the next cycle, partial frame discarded, no Done pulse.
- FSM states:
  - IDLE: line high. If FIFO non-empty: pop, latch word, latch parity mode and stop count, drive o_Tx_Serial<=0, enter START.
  - START: remain CLKS_PER_BIT cycles, then enter DATA.
  - DATA: drive bit[idx], idx from 0 to DATA_BITS-1, each held CLKS_PER_BIT cycles. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: even mode drives the XOR of the data bits; odd mode drives its inverse. Held CLKS_PER_BIT cycles.
  - STOP: line high for 1 or 2 bit periods. At the final cycle: pulse o_Tx_Done (visible the following cycle). If the FIFO is non-empty, pop and go directly to START with the line low on the next cycle; otherwise go to IDLE.
- Every bit period is exactly CLKS_PER_BIT cycles. Frame length is (1 + DATA_BITS + P + S) * CLKS_PER_BIT cycles, where P is 0 or 1 and S is 1 or 2.
- Latency: a word accepted at edge T into an empty FIFO while in IDLE appears as o_Tx_Serial=0 after edge T+1.
- o_Tx_Active is high from START entry through the final STOP cycle. It stays high across back-to-back frames.
- FIFO rules:
  - o_Tx_Ready is derived from registered occupancy, so a write while full is refused even if a pop occurs in the same cycle.
  - Simultaneous push and pop in a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Changes to i_Parity_Mode or i_Two_Stop mid-frame have no effect until the next frame start.
- The bit counter is wide enough for CLKS_PER_BIT-1 ($clog2(CLKS_PER_BIT)). The index counter is wide enough for DATA_BITS-1.

Decomposition:
- Package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP);
  - the parity-mode enum (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2);
  - localparam defaults for CLKS_PER_BIT, shared with the receiver.
- One sub-module: sync_fifo #(WIDTH, DEPTH) with push/pop/full/empty/count, synchronous active-high reset. It is reused later by the RX side.

Test Plan:
- CLKS_PER_BIT=4, 8N1, write 0xA5 once → line after T+1: 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles. o_Tx_Done pulses once, 40 cycles after the start bit begins. o_Tx_Active is high for exactly 40 cycles.
- Write 0x07 with i_Parity_Mode=1, i_Two_Stop=1 → parity bit 1, then two stop periods (8 cycles high), frame 48 cycles. Repeat with mode 2 → parity bit 0.
- Write 5 words in consecutive cycles with FIFO_DEPTH=4 → first 4 accepted (the first is popped immediately). o_Tx_Ready drops when the count reaches 4. The 5th write is accepted if not full, else o_Overflow pulses and the word is dropped. Queued frames go out with no idle cycle between them, and each produces one Done pulse.
- Assert i_Rst midway through DATA bit 3 → line =1 on the next cycle, o_Fifo_Count=0, o_Tx_Active=0, no o_Tx_Done. A new write afterwards transmits cleanly.
- DATA_BITS=7, write 0x55 with odd parity → 7 data bits 1,0,1,0,1,0,1, parity 1 (four ones, odd → 1), then stop. o_Tx_Byte bit 7 is not applicable.
- Toggle i_Parity_Mode during a frame → the current frame keeps its latched mode and the next frame uses the new mode.
